data_memory_sync: RTL

//   Clocked, byte-addressable data memory for the CPU MEM stage, with req/ack handshake.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/data_memory_sync.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the MEM-stage data memory.
package dmem_pkg;

    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DATA_W      = 32;

    // Access size encodings carried on size_i
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store alignment, load extraction/extension, alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        i_offset,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_load_word,
    output logic [3:0]        o_byte_en,
    output logic [DATA_W-1:0] o_store_word,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misalign
);

    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_load_shifted;

    // Misaligned or reserved accesses get no byte enables and a zero load value
    always_comb begin
        w_shamt        = {i_offset, 3'b000};
        w_load_shifted = i_load_word >> w_shamt;
        o_byte_en      = 4'b0000;
        o_store_word   = '0;
        o_load_data    = '0;
        o_misalign     = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_byte_en    = 4'b0001 << i_offset;
                o_store_word = {24'd0, i_store_data[7:0]} << w_shamt;
                o_load_data  = {{24{~i_unsigned & w_load_shifted[7]}}, w_load_shifted[7:0]};
            end
            SZ_HALF: begin
                if (i_offset[0]) begin
                    o_misalign = 1'b1;
                end else begin
                    o_byte_en    = 4'b0011 << i_offset;
                    o_store_word = {16'd0, i_store_data[15:0]} << w_shamt;
                    o_load_data  = {{16{~i_unsigned & w_load_shifted[15]}}, w_load_shifted[15:0]};
                end
            end
            SZ_WORD: begin
                if (i_offset != 2'b00) begin
                    o_misalign = 1'b1;
                end else begin
                    o_byte_en    = 4'b1111;
                    o_store_word = i_store_data;
                    o_load_data  = w_load_shifted;
                end
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Byte-addressable data memory with req/ack handshake and programmable wait states.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_W-1:0]     write_data_i,
    output logic [DATA_W-1:0]     read_data_o,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic                  misalign_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_BYTES);
    localparam int unsigned WORDS    = DEPTH_BYTES / 4;
    localparam int unsigned WIDX_W   = (IDX_W > 2) ? IDX_W - 2 : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [DATA_W-1:0] r_mem [WORDS];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [IDX_W-1:0]  r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_misalign;
    logic [DATA_W-1:0] r_rdata;

    logic              w_idle;
    logic              w_accept;
    logic              w_go_done;
    logic              w_we;
    logic              w_uns;
    logic [1:0]        w_size;
    logic [IDX_W-1:0]  w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [WIDX_W-1:0] w_widx;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_st_word;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_mis;
    logic              w_unused;

    // High address bits are don't-care: storage wraps modulo DEPTH_BYTES
    assign w_unused = ^address_i;

    // Live request while idle (single-cycle latency completes on the accept edge), latched request otherwise
    always_comb begin
        w_idle    = (r_state == IDLE);
        w_accept  = w_idle && req_i;
        w_we      = w_idle ? we_i : r_we;
        w_uns     = w_idle ? unsigned_i : r_uns;
        w_size    = w_idle ? size_i : r_size;
        w_addr    = w_idle ? address_i[IDX_W-1:0] : r_addr;
        w_wdata   = w_idle ? write_data_i : r_wdata;
        w_widx    = WIDX_W'(w_addr >> 2);
        w_go_done = (w_accept && (LATENCY <= 1)) ||
                    ((r_state == WAIT) && (r_cnt <= CNT_W'(1)));
    end

    dmem_lane_align u_lane_align (
        .i_offset     (w_addr[1:0]),
        .i_size       (w_size),
        .i_unsigned   (w_uns),
        .i_store_data (w_wdata),
        .i_load_word  (r_mem[w_widx]),
        .o_byte_en    (w_be),
        .o_store_word (w_st_word),
        .o_load_data  (w_ld_data),
        .o_misalign   (w_mis)
    );

    // Capture the request fields on acceptance
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we    <= we_i;
            r_uns   <= unsigned_i;
            r_size  <= size_i;
            r_addr  <= address_i[IDX_W-1:0];
            r_wdata <= write_data_i;
        end
    end

    // Handshake FSM with wait counter; completion registers ack, load data and misalign together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= CNT_LOAD;
                        if (w_go_done) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_go_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_go_done) begin
                r_ack      <= 1'b1;
                r_busy     <= 1'b0;
                r_misalign <= w_mis;
                r_rdata    <= (w_we || w_mis) ? '0 : w_ld_data;
            end
        end
    end

    // Store commit on the completion edge; a reset on that edge discards it
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_go_done && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_st_word[8*b +: 8];
                end
            end
        end
    end

    assign read_data_o = r_rdata;
    assign ack_o       = r_ack;
    assign busy_o      = r_busy;
    assign misalign_o  = r_misalign;

endmodule
